// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/ready/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    // The sequencer issuing operations.
    modport master (
        output start, a, b, bin,
        input  ready, done, diff, bout, ovf
    );

    // The subtractor serving them.
    modport slave (
        input  start, a, b, bin,
        output ready, done, diff, bout, ovf
    );

endinterface

// File: rtl/half_subtractor.sv
// Half-subtractor: d = x - y, borrow when x=0 and y=1.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - bin LSB first, one bit per clock,
// with a registered borrow feeding a full-subtractor built from two half-subtractors.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] r_cat;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             d_ab;
    logic             bo_ab;
    logic             d_bit;
    logic             bo_br;
    logic             br_next;
    logic             last_bit;

    half_subtractor u_hs_ab (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .d  (d_ab),
        .bo (bo_ab)
    );

    half_subtractor u_hs_br (
        .x  (d_ab),
        .y  (br),
        .d  (d_bit),
        .bo (bo_br)
    );

    assign br_next  = bo_ab | bo_br;
    // Result register holds the WIDTH-1 bits already produced; the bit being
    // computed completes the word on the final edge.
    assign r_cat    = {d_bit, r_sh};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bus.ready <= 1'b1;
            bus.done  <= 1'b0;
            bus.diff  <= '0;
            bus.bout  <= 1'b0;
            bus.ovf   <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            cnt       <= '0;
            br        <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh      <= bus.a;
                        b_sh      <= bus.b;
                        br        <= bus.bin;
                        a_msb     <= bus.a[WIDTH-1];
                        b_msb     <= bus.b[WIDTH-1];
                        cnt       <= '0;
                        bus.ready <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= r_cat[WIDTH-1:1];
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        bus.diff <= r_cat;
                        bus.bout <= br_next;
                        // Signed overflow uses only the operand MSBs; bin is excluded.
                        bus.ovf  <= (a_msb != b_msb) & (d_bit != a_msb);
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a driver queues hand-computed results,
// a monitor pops and compares them whenever done pulses.
module tb_serial_subtractor;

    localparam int W  = 8;
    localparam int NV = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q[$];

    int cyc    = 0;
    int checks = 0;
    int passes = 0;

    logic [W-1:0] held_d     = '0;
    logic         held_bo    = 1'b0;
    logic         held_ov    = 1'b0;
    logic         after_done = 1'b0;

    // Directed vectors: a, b, bin, expected diff, bout, ovf (hand-computed).
    logic [W-1:0] va  [NV] = '{8'h5A, 8'h00, 8'h80, 8'h7F, 8'h10, 8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01};
    logic [W-1:0] vb  [NV] = '{8'h3C, 8'h01, 8'h01, 8'hFF, 8'h0F, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h02};
    logic         vbi [NV] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    logic [W-1:0] vd  [NV] = '{8'h1E, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'hFF, 8'hFE};
    logic         vbo [NV] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
    logic         vov [NV] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: scoreboard pop on done, hold checks otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (after_done) begin
                chk("ready_after_done", 32'(bus.ready), 32'(1));
                chk("done_single_pulse", 32'(bus.done), 32'(0));
                after_done = 1'b0;
            end
            if (bus.done) begin
                chk("ready_during_done", 32'(bus.ready), 32'(0));
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_done: got done=1 with diff=0x%0h, expected no pending op", bus.diff);
                end else begin
                    e = q.pop_front();
                    chk("diff", 32'(bus.diff), 32'(e.d));
                    chk("bout", 32'(bus.bout), 32'(e.bo));
                    chk("ovf", 32'(bus.ovf), 32'(e.ov));
                    chk("latency", 32'(cyc - e.acc), 32'(W));
                    held_d  = e.d;
                    held_bo = e.bo;
                    held_ov = e.ov;
                end
                after_done = 1'b1;
            end else begin
                chk("diff_hold", 32'(bus.diff), 32'(held_d));
                chk("bout_hold", 32'(bus.bout), 32'(held_bo));
                chk("ovf_hold", 32'(bus.ovf), 32'(held_ov));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input logic [W-1:0] ed, input logic ebo, input logic eov,
                         output int acc);
        int n;
        n   = 0;
        acc = -1;
        @(posedge clk); #2;
        while (!bus.ready && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (!bus.ready) begin
            checks++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected ready=1", n);
            return;
        end
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bi;
        acc       = cyc + 1;
        q.push_back('{ed, ebo, eov, acc});
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !bus.ready) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d ops pending, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'(1));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_diff", 32'(bus.diff), 32'(0));
        chk("rst_bout", 32'(bus.bout), 32'(0));
        chk("rst_ovf", 32'(bus.ovf), 32'(0));
    endtask

    initial begin
        int acc;
        int prev_acc;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        check_reset_state();

        // Back-to-back directed vectors.
        prev_acc = -1;
        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i], vbi[i], vd[i], vbo[i], vov[i], acc);
            if (i > 0 && acc >= 0 && prev_acc >= 0)
                chk("b2b_interval", 32'(acc - prev_acc), 32'(W + 2));
            prev_acc = acc;
        end
        drain();

        // Start during RUN and operand changes mid-run must be ignored.
        issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, acc);
        @(posedge clk); #2;
        @(posedge clk); #2;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        @(posedge clk); #2;
        bus.start = 1'b0;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.bin   = 1'b1;
        drain();
        repeat (4) @(posedge clk);
        #2;

        // Reset in the middle of a run discards the operation.
        issue(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, acc);
        @(posedge clk); #2;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n      = 1'b1;
        q.delete();
        held_d     = '0;
        held_bo    = 1'b0;
        held_ov    = 1'b0;
        after_done = 1'b0;
        check_reset_state();

        issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, acc);
        drain();
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
